pc_fetch_unit: RTL and testbench



---
 rtl/pc_fetch_pkg.sv | 14 +
 rtl/pc_fetch_unit_sat_counter.sv | 21 ++
 rtl/pc_fetch_unit.sv | 108 ++++++++++
 tb/tb_pc_fetch_unit.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/pc_fetch_pkg.sv
// rtl/pc_fetch_pkg.sv - shared types and constants for the PC fetch stage
package pc_fetch_pkg;

  localparam int XLEN        = 64;
  localparam int INSTR_BYTES = 4;

  typedef enum logic [1:0] {
    INIT = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2,
    TRAP = 2'd3
  } fetch_state_t;

endpackage

// File: rtl/pc_fetch_unit_sat_counter.sv
// rtl/pc_fetch_unit_sat_counter.sv - saturating up-counter with enable and async reset
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  output logic [W-1:0] count
);

  localparam logic [W-1:0] ONE = {{(W-1){1'b0}}, 1'b1};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (en && (count != '1)) begin
      count <= count + ONE;
    end
  end

endmodule

// File: rtl/pc_fetch_unit.sv
// rtl/pc_fetch_unit.sv - PC register and fetch sequencing with end-of-image halt
// FETCH_BOUNDS_CHECK_EN enables branch-target legality checking and the TRAP state.
module pc_fetch_unit
  import pc_fetch_pkg::*;
#(
  parameter logic [63:0] RESET_PC   = 64'h0,
  parameter int          IMEM_BYTES = 108,
  parameter int          CNT_W      = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall,
  input  logic             branch_taken,
  input  logic [63:0]      branch_target,
  output logic [63:0]      Inst_Address,
  output logic             fetch_valid,
  output logic             halted,
  output logic             trap,
  output logic [63:0]      trap_pc,
  output logic [CNT_W-1:0] fetch_count
);

  localparam logic [XLEN-1:0] LAST_PC = XLEN'(IMEM_BYTES - INSTR_BYTES);

  fetch_state_t    state, state_nxt;
  logic [XLEN-1:0] pc, pc_nxt;
  logic [XLEN:0]   seq_sum;
  logic            target_ok;
  logic            cnt_en;
  logic            trap_fire;

  // One extra bit so a PC near the top of the address space cannot wrap past the limit
  assign seq_sum = {1'b0, pc} + (XLEN + 1)'(INSTR_BYTES);

`ifdef FETCH_BOUNDS_CHECK_EN
  assign target_ok = (branch_target[1:0] == 2'b00) && (branch_target <= LAST_PC);
`else
  assign target_ok = 1'b1;
`endif

  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    cnt_en    = 1'b0;
    trap_fire = 1'b0;
    case (state)
      INIT: state_nxt = RUN;
      RUN: begin
        if (!stall) begin
          cnt_en = 1'b1;
          if (branch_taken) begin
            if (target_ok) begin
              pc_nxt = branch_target;
            end else begin
              state_nxt = TRAP;
              trap_fire = 1'b1;
            end
          end else if (seq_sum > {1'b0, LAST_PC}) begin
            state_nxt = HALT;
          end else begin
            pc_nxt = seq_sum[XLEN-1:0];
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= INIT;
      pc    <= RESET_PC;
    end else begin
      state <= state_nxt;
      pc    <= pc_nxt;
    end
  end

`ifdef FETCH_BOUNDS_CHECK_EN
  logic [XLEN-1:0] tpc;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tpc <= '0;
    end else if (trap_fire) begin
      tpc <= branch_target;
    end
  end

  assign trap    = (state == TRAP);
  assign trap_pc = tpc;
`else
  assign trap    = 1'b0;
  assign trap_pc = '0;
`endif

  sat_counter #(.W(CNT_W)) u_fetch_cnt (
    .clk   (clk),
    .rst   (reset),
    .en    (cnt_en),
    .count (fetch_count)
  );

  assign Inst_Address = pc;
  assign fetch_valid  = (state == RUN);
  assign halted       = (state == HALT);

endmodule

// File: tb/tb_pc_fetch_unit.sv
// tb/tb_pc_fetch_unit.sv - self-checking bench for pc_fetch_unit against a behavioural model
module tb_pc_fetch_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        stall = 1'b0;
  logic        branch_taken = 1'b0;
  logic [63:0] branch_target = 64'h0;

  logic [63:0] a_addr, a_tpc, b_addr, b_tpc;
  logic        a_valid, a_halted, a_trap, b_valid, b_halted, b_trap;
  logic [31:0] a_cnt;
  logic [3:0]  b_cnt;

  int tests = 0;
  int fails = 0;

  // Reference state: the fetch address, which phase the stage is in, and an unbounded count
  logic [63:0] m_pc, m_tpc;
  bit          m_init, m_run, m_halt, m_trap;
  longint      m_count;

  pc_fetch_unit dut (
    .clk(clk), .reset(reset), .stall(stall), .branch_taken(branch_taken),
    .branch_target(branch_target), .Inst_Address(a_addr), .fetch_valid(a_valid),
    .halted(a_halted), .trap(a_trap), .trap_pc(a_tpc), .fetch_count(a_cnt)
  );

  pc_fetch_unit #(.CNT_W(4)) dut_sat (
    .clk(clk), .reset(reset), .stall(stall), .branch_taken(branch_taken),
    .branch_target(branch_target), .Inst_Address(b_addr), .fetch_valid(b_valid),
    .halted(b_halted), .trap(b_trap), .trap_pc(b_tpc), .fetch_count(b_cnt)
  );

  always #5 clk = ~clk;

  function automatic bit legal(input logic [63:0] t);
`ifdef FETCH_BOUNDS_CHECK_EN
    return (t % 4 == 0) && (t <= 64'd104);
`else
    return 1'b1;
`endif
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    longint sat;
    sat = (m_count > 15) ? 15 : m_count;
    check("addr", a_addr, m_pc);
    check("valid", 64'(a_valid), 64'(m_run));
    check("halted", 64'(a_halted), 64'(m_halt));
    check("trap", 64'(a_trap), 64'(m_trap));
    check("trap_pc", a_tpc, m_tpc);
    check("count", 64'(a_cnt), 64'(m_count));
    check("sat_count", 64'(b_cnt), 64'(sat));
    check("sat_inst", {b_addr[59:0], b_valid, b_halted, b_trap, 1'b0},
          {m_pc[59:0], m_run, m_halt, m_trap, 1'b0});
  endtask

  task automatic model_edge();
    if (m_init) begin
      m_init = 1'b0;
      m_run  = 1'b1;
    end else if (m_run && !stall) begin
      m_count++;
      if (branch_taken) begin
        if (legal(branch_target)) begin
          m_pc = branch_target;
        end else begin
          m_run  = 1'b0;
          m_trap = 1'b1;
          m_tpc  = branch_target;
        end
      end else if ({1'b0, m_pc} + 65'd4 > 65'd104) begin
        m_run  = 1'b0;
        m_halt = 1'b1;
      end else begin
        m_pc = m_pc + 64'd4;
      end
    end
  endtask

  task automatic step(input bit s, input bit b, input logic [63:0] t);
    stall         = s;
    branch_taken  = b;
    branch_target = t;
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #1;
    m_pc = 64'h0; m_tpc = 64'h0; m_count = 0;
    m_init = 1'b1; m_run = 1'b0; m_halt = 1'b0; m_trap = 1'b0;
    check_all();
    @(posedge clk);
    #1;
    stall = 1'b0; branch_taken = 1'b0; branch_target = 64'h0;
    reset = 1'b0;
  endtask

  task automatic run_to(input logic [63:0] target_pc);
    for (int i = 0; i < 40 && m_run && m_pc != target_pc; i++) step(1'b0, 1'b0, 64'h0);
    check("run_to", a_addr, target_pc);
  endtask

  function automatic logic [63:0] rand_target();
    case ($urandom_range(0, 4))
      0, 1:    return 64'($urandom_range(0, 26) * 4);
      2:       return 64'($urandom_range(0, 107));
      3:       return 64'($urandom_range(105, 300));
      default: return {$urandom, $urandom};
    endcase
  endfunction

  initial begin
    // Plain sequential run to the end of the image
    do_reset();
    step(1'b0, 1'b0, 64'h0);
    check("first_fetch", a_addr, 64'd0);
    for (int i = 0; i < 27; i++) step(1'b0, 1'b0, 64'h0);
    check("halt_flag", 64'(a_halted), 64'd1);
    check("halt_pc", a_addr, 64'd104);
    check("halt_cnt", 64'(a_cnt), 64'd27);
    check("halt_sat", 64'(b_cnt), 64'd15);
    for (int i = 0; i < 3; i++) step(1'($urandom), 1'b1, 64'd8);

    // Branch back, then stall with a held redirect
    do_reset();
    step(1'b0, 1'b0, 64'h0);
    run_to(64'd56);
    step(1'b0, 1'b1, 64'd8);
    check("branch_pc", a_addr, 64'd8);
    run_to(64'd24);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 64'd60);
    check("stall_pc", a_addr, 64'd24);
    step(1'b0, 1'b1, 64'd60);
    check("post_stall_pc", a_addr, 64'd60);

    // Misaligned target
    step(1'b0, 1'b1, 64'h4A);
`ifdef FETCH_BOUNDS_CHECK_EN
    check("mis_trap", 64'(a_trap), 64'd1);
    check("mis_trap_pc", a_tpc, 64'h4A);
    check("mis_pc_held", a_addr, 64'd60);
`else
    check("mis_pc", a_addr, 64'h4A);
`endif
    step(1'b0, 1'b0, 64'h0);

    // Asynchronous reset in the middle of a run
    do_reset();
    step(1'b0, 1'b0, 64'h0);
    run_to(64'd40);
    #3;
    do_reset();
    check("async_addr", a_addr, 64'd0);
    step(1'b0, 1'b0, 64'h0);
    run_to(64'd12);

    // Out-of-range and last-legal branch targets
    do_reset();
    step(1'b0, 1'b0, 64'h0);
    step(1'b0, 1'b1, 64'd108);
    step(1'b0, 1'b0, 64'h0);
    do_reset();
    step(1'b0, 1'b0, 64'h0);
    step(1'b0, 1'b1, 64'd104);
    check("last_legal", a_addr, 64'd104);
    step(1'b0, 1'b0, 64'h0);
    check("last_halt", 64'(a_halted), 64'd1);

    // Randomised runs
    for (int r = 0; r < 10; r++) begin
      do_reset();
      for (int i = 0; i < 40; i++)
        step($urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0, rand_target());
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
